// File: rtl/warmup2_mpadder_loader_if.sv
// Handshake bundle between the operand stream, the 128-bit adder and the result stream.
// The loader takes the slave modport; the surrounding environment takes master.
interface warmup2_mpadder_loader_if;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic         add_start;
    logic [127:0] add_a;
    logic [127:0] add_b;
    logic [128:0] add_c;
    logic         add_done;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_last;
    logic         out_ready;
    logic         busy;
    logic         error;

    modport master (
        output in_valid, in_data, add_c, add_done, out_ready,
        input  in_ready, add_start, add_a, add_b, out_valid, out_data, out_last, busy, error
    );

    modport slave (
        input  in_valid, in_data, add_c, add_done, out_ready,
        output in_ready, add_start, add_a, add_b, out_valid, out_data, out_last, busy, error
    );
endinterface

// File: rtl/warmup2_mpadder_loader.sv
// Collects eight 32-bit words into two 128-bit operands, drives an external adder and
// streams the 129-bit sum back out as five 32-bit words, with a watchdog on the adder.
module warmup2_mpadder_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     resetn,
    warmup2_mpadder_loader_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StSend} state_e;

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    state_e         state_q, state_d;
    logic [2:0]     in_cnt_q, in_cnt_d;
    logic [2:0]     out_cnt_q, out_cnt_d;
    logic [15:0]    wait_cnt_q, wait_cnt_d;
    logic [127:0]   a_q, a_d;
    logic [127:0]   b_q, b_d;
    logic [128:0]   res_q, res_d;
    logic           error_q, error_d;
    logic           in_ready_q, in_ready_d;
    logic           add_start_q, add_start_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic           busy_q, busy_d;
    logic           in_xfer, out_xfer;
    logic [31:0]    out_word;

    assign in_xfer  = in_ready_q & bus.in_valid;
    assign out_xfer = out_valid_q & bus.out_ready;

    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        wait_cnt_d = wait_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        error_d    = error_q;

        case (state_q)
            StIdle: state_d = StLoad;
            StLoad: begin
                if (in_xfer) begin
                    // Counter bit 2 selects operand, bits 1:0 the word lane.
                    if (!in_cnt_q[2]) a_d[{in_cnt_q[1:0], 5'd0} +: 32] = bus.in_data;
                    else              b_d[{in_cnt_q[1:0], 5'd0} +: 32] = bus.in_data;
                    in_cnt_d = in_cnt_q + 3'd1;
                    if (in_cnt_q == 3'd7) state_d = StStart;
                end
            end
            StStart: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                if (bus.add_done) begin
                    res_d     = bus.add_c;
                    out_cnt_d = '0;
                    state_d   = StSend;
                end else if (wait_cnt_q == TimeoutLast) begin
                    error_d = 1'b1;
                    state_d = StLoad;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            StSend: begin
                if (out_xfer) begin
                    if (out_cnt_q == 3'd4) begin
                        out_cnt_d = '0;
                        state_d   = StLoad;
                    end else begin
                        out_cnt_d = out_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Control outputs are registered from the next state so they align with state_q.
        in_ready_d  = (state_d == StLoad);
        add_start_d = (state_d == StStart);
        out_valid_d = (state_d == StSend);
        out_last_d  = (state_d == StSend) && (out_cnt_d == 3'd4);
        busy_d      = (state_d == StStart) || (state_d == StWait) || (state_d == StSend);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            error_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            add_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            error_q     <= error_d;
            in_ready_q  <= in_ready_d;
            add_start_q <= add_start_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        case (out_cnt_q)
            3'd0:    out_word = res_q[31:0];
            3'd1:    out_word = res_q[63:32];
            3'd2:    out_word = res_q[95:64];
            3'd3:    out_word = res_q[127:96];
            default: out_word = {31'b0, res_q[128]};
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.add_start = add_start_q;
    assign bus.add_a     = a_q;
    assign bus.add_b     = b_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_valid_q ? out_word : 32'd0;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.error     = error_q;

endmodule

// File: doc/warmup2_mpadder_loader.md
WARMUP2_MPADDER_LOADER -- requirements
Module: warmup2_mpadder_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of WAIT-state cycles allowed before add_done arrives (range 1..65535).
REQ-002 SHALL use one clock and an asynchronous, active-low reset, with ports named clk and resetn.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand word present on in_data.
REQ-006 in_data  input  32  operand word.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 add_start  output  1  one-cycle start pulse to the 128-bit adder.
REQ-009 add_a  output  128  operand A to the adder.
REQ-010 add_b  output  128  operand B to the adder.
REQ-011 add_c  input  129  adder result.
REQ-012 add_done  input  1  adder result valid.
REQ-013 out_valid  output  1  result word present on out_data.
REQ-014 out_data  output  32  result word.
REQ-015 out_last  output  1  marks the final (5th) result word.
REQ-016 out_ready  input  1  consumer accepts out_data this cycle.
REQ-017 busy  output  1  high in START, WAIT and SEND.
REQ-018 error  output  1  sticky timeout flag.

Function
REQ-019 SHALL implement states IDLE, LOAD, START, WAIT and SEND; state SHALL reset to IDLE, and IDLE SHALL go to LOAD unconditionally on the next edge.
REQ-020 In LOAD, in_ready SHALL be 1; a word SHALL transfer only on an edge where in_valid=1 and in_ready=1; in_ready SHALL be 0 in every other state.
REQ-021 Word order SHALL be: words 0-3 form A and words 4-7 form B, least-significant word first (word k goes to bits [32(k mod 4)+31 : 32(k mod 4)]).
REQ-022 Gaps in in_valid SHALL NOT affect assembly; the 3-bit word counter SHALL advance only on a transfer.
REQ-023 After the 8th transfer the state SHALL be START on the next cycle, with add_start=1 for exactly that one cycle; the state SHALL then go to WAIT.
REQ-024 add_a and add_b SHALL be stable from START until SEND is exited.
REQ-025 add_done SHALL be sampled only in WAIT; add_done outside WAIT SHALL be ignored.
REQ-026 In WAIT, on add_done=1 the block SHALL register add_c into a 129-bit result register and enter SEND on the next cycle.
REQ-027 The WAIT cycle counter SHALL count up from 0 on WAIT entry; if it reaches TIMEOUT_CYCLES without add_done, the block SHALL set error=1, discard the result, and return to LOAD (in_ready=1 on the next cycle).
REQ-028 error SHALL remain 1 until reset; the block SHALL keep operating normally while error=1.
REQ-029 SEND SHALL emit 5 words, least-significant first: result[31:0], [63:32], [95:64], [127:96], then {31'b0, result[128]}.
REQ-030 In SEND, out_valid SHALL be 1; a word SHALL transfer on an edge where out_valid=1 and out_ready=1; out_data and out_last SHALL hold while out_ready=0.
REQ-031 out_last SHALL be 1 only while the 5th word is presented.
REQ-032 After the 5th transfer the state SHALL be LOAD on the next cycle.
REQ-033 out_valid, out_last and add_start SHALL be 0 outside SEND, SEND and START respectively.
REQ-034 Bandwidth: with continuous valid/ready, one operand set SHALL complete in 8 + 1 + adder latency + 1 + 5 cycles.

Reset
REQ-035 While resetn=0, every output SHALL be 0, including add_a, add_b, out_data and error.
REQ-036 Asserting resetn in any state SHALL immediately abort the operation and discard partial operands and results; the word counters, timeout counter and result register SHALL clear.
REQ-037 In the first cycle after resetn rises, state SHALL be IDLE and in_ready SHALL be 0; from the second cycle, in_ready SHALL be 1.

Verification
REQ-038 Basic (adder = warmup2_mpadder): in words 62e4fa0d, 7834fad7, da449768, cbc87cf0, fa86ee6c, cf335529, 5b948a6c, 88f32f2f -> out 5d6be879, 47685001, 35d921d5, 54bbac20, 00000001, with out_last=1 on the 5th word only; add_start is exactly one pulse.
REQ-039 Backpressure: same stimulus, out_ready=0 for 3 cycles while word 3 is presented -> out_data holds 35d921d5 and out_valid stays 1; the sequence is otherwise unchanged.
REQ-040 Max carry: A = B = all ones -> out fffffffe, ffffffff, ffffffff, ffffffff, 00000001.
REQ-041 Timeout: TIMEOUT_CYCLES=16 with an adder model that never asserts done -> error=1 after 16 WAIT cycles, out_valid never asserted, in_ready=1 on the next cycle; a following operand set with a working adder still produces a correct result.
REQ-042 Reset mid-load: 5 words accepted, then resetn pulsed low -> all outputs 0; eight zero words afterward -> five 00000000 output words.
REQ-043 Random in_valid gaps and random out_ready stalls over 1000 operand sets -> every result matches a reference model of A+B.
